rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Two-port arbiter sharing one single-port synchronous SRAM between the core's instruction-fetch port and its data port. It sits between the core's IMEM/DMEM interfaces and a unified memory macro with one-cycle read latency. It issues per-port grants and tracks which port owns the pending read, so each read response returns to its requester. Contention is resolved by fixed data priority, or by round-robin when compiled in.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_i  in  1  fetch request; held with address until granted
- imem_addr_i  in  ADDR_WIDTH  fetch byte address
- imem_gnt_o  out  1  fetch accepted this cycle
- imem_rvalid_o  out  1  fetch data valid
- imem_rdata_o  out  DATA_WIDTH  fetch data
- dmem_req_i  in  1  data request; held with all qualifiers until granted
- dmem_we_i  in  1  1 = write, 0 = read
- dmem_be_i  in  4  write byte enables
- dmem_addr_i  in  ADDR_WIDTH  data byte address
- dmem_wdata_i  in  DATA_WIDTH  write data
- dmem_gnt_o  out  1  data request accepted this cycle
- dmem_rvalid_o  out  1  load data valid (reads only)
- dmem_rdata_o  out  DATA_WIDTH  load data
- mem_en_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  ADDR_WIDTH  SRAM byte address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe

## Operation
- Grant is combinational, in the same cycle as the request. At most one gnt per cycle. mem_en_o = imem_gnt_o | dmem_gnt_o.
- SRAM outputs mux from the granted port. The fetch port drives mem_we_o=0 and mem_be_o=4'hF. mem_wdata_o=dmem_wdata_i always.
- No request pending: all mem_* outputs are 0.
- Response FSM register resp_q has three states:
  - IDLE: no read outstanding.
  - RD_I: fetch read outstanding.
  - RD_D: data read outstanding.
- Next state: a granted fetch → RD_I; a granted data read → RD_D; a granted write or no grant → IDLE. Every state may accept a new grant, so back-to-back accesses run at 1 access/cycle.
- imem_rvalid_o = (resp_q==RD_I); dmem_rvalid_o = (resp_q==RD_D).
- rdata outputs are mem_rdata_i gated by their own rvalid; they are 0 otherwise.
- Writes complete at grant and produce no rvalid.
- Contention, both requesting, default: data wins; fetch stalls until the data request drops.
- Single requester: always granted immediately, regardless of priority state.
- A request that is not granted must stay asserted and stable. If it changes, behaviour is undefined; a bench assertion flags it.

## Timing
- Read latency: gnt in cycle N, rvalid and data in cycle N+1.
- Write latency: the SRAM is written on the clock edge ending the gnt cycle.
- Reset (rst_n low, asynchronous):
  - resp_q=IDLE, priority pointer=imem.
  - All gnt, rvalid, rdata and mem_* outputs are 0 while rst_n is low, regardless of requests.
- Reset during an outstanding read: the response is dropped and no rvalid appears after reset release.
- First grant is possible in the first cycle with rst_n high.
- Same-cycle grant and rvalid on different ports is legal, e.g. dmem_rvalid_o with imem_gnt_o.

## Configuration
- RV_MEM_ARB_RR_EN, undefined: fixed priority, data over fetch.
- RV_MEM_ARB_RR_EN, defined: 1-bit round-robin pointer prio_q.
  - On contention, the port named by prio_q wins.
  - After any contended grant, prio_q flips to the losing port.
  - Uncontended grants leave prio_q unchanged.
  - Reset value of prio_q is imem.
  - Neither port waits more than one contended access.

## Test plan
- Reset:
  - Stimulus: rst_n low, both reqs high.
  - Required: gnt/rvalid/mem_en all 0.
  - Then: release, imem_req_i=1 with addr 0x0000_0010. Required: imem_gnt_o=1 and mem_addr_o=0x10 in the first cycle; imem_rvalid_o=1 the next cycle with preloaded data 0xDEAD_BEEF.
- Back-to-back fetch:
  - Stimulus: fetch addrs 0x0, 0x4, 0x8 on consecutive cycles.
  - Required: three consecutive grants, then three consecutive rvalids carrying the preloaded words in order.
- Write then read:
  - Stimulus: dmem write 0x100, wdata 0x1234_5678, be 4'b0011; then dmem read 0x100.
  - Required: no rvalid after the write; the read returns old[31:16] with 0x5678 in the low half.
- Contention, default build:
  - Stimulus: imem and dmem requesting for 3 cycles, dmem a read.
  - Required: dmem granted every cycle, imem_gnt_o=0 throughout. When dmem drops, imem is granted the same cycle.
- Contention, RV_MEM_ARB_RR_EN defined:
  - Stimulus: both requesting continuously for 4 accesses.
  - Required: grants alternate imem, dmem, imem, dmem, and each rvalid lands on the matching port.
- Reset mid-read:
  - Stimulus: dmem read granted, rst_n pulsed low before the next edge.
  - Required: dmem_rvalid_o never asserts; resp_q=IDLE after release.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle between the core IMEM/DMEM ports, rv_mem_arbiter and the shared SRAM.
// slave = arbiter side, master = core/SRAM side (testbench drives this view).
interface rv_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic                  imem_gnt_o;
    logic                  imem_rvalid_o;
    logic [DATA_WIDTH-1:0] imem_rdata_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [3:0]            dmem_be_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic                  dmem_gnt_o;
    logic                  dmem_rvalid_o;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_gnt_o, imem_rvalid_o, imem_rdata_o,
        input  dmem_req_i, dmem_we_i, dmem_be_i, dmem_addr_i, dmem_wdata_i,
        output dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_gnt_o, imem_rvalid_o, imem_rdata_o,
        output dmem_req_i, dmem_we_i, dmem_be_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Fetch/data arbiter for one single-port SRAM with one-cycle read latency.
// Define RV_MEM_ARB_RR_EN for round-robin contention; default is data-over-fetch priority.
module rv_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRdI, StRdD} resp_e;

    resp_e r_resp_q, w_resp_d;

    logic                  w_pick_d;
    logic                  w_gnt_i;
    logic                  w_gnt_d;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_rvalid_i;
    logic                  w_rvalid_d;

`ifdef RV_MEM_ARB_RR_EN
    // r_prio_q: 0 = fetch port favoured, 1 = data port favoured.
    logic r_prio_q, w_prio_d;

    always_comb begin
        w_pick_d = bus.dmem_req_i & (~bus.imem_req_i | r_prio_q);
    end

    always_comb begin
        w_prio_d = r_prio_q;
        if (bus.imem_req_i && bus.dmem_req_i) begin
            w_prio_d = ~w_pick_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_q <= 1'b0;
        end else begin
            r_prio_q <= w_prio_d;
        end
    end
`else
    always_comb begin
        w_pick_d = bus.dmem_req_i;
    end
`endif

    // Grants are forced low while reset is asserted, whatever the requests do.
    always_comb begin
        w_gnt_d = rst_n & w_pick_d;
        w_gnt_i = rst_n & bus.imem_req_i & ~w_pick_d;
    end

    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        w_addr          = '0;
        w_wdata         = '0;
        if (w_gnt_d) begin
            bus.mem_en_o = 1'b1;
            bus.mem_we_o = bus.dmem_we_i;
            bus.mem_be_o = bus.dmem_be_i;
            w_addr       = bus.dmem_addr_i;
            w_wdata      = bus.dmem_wdata_i;
        end else if (w_gnt_i) begin
            bus.mem_en_o = 1'b1;
            bus.mem_be_o = 4'hF;
            w_addr       = bus.imem_addr_i;
            w_wdata      = bus.dmem_wdata_i;
        end
        bus.mem_addr_o  = w_addr;
        bus.mem_wdata_o = w_wdata;
        bus.imem_gnt_o  = w_gnt_i;
        bus.dmem_gnt_o  = w_gnt_d;
    end

    always_comb begin
        w_resp_d = StIdle;
        if (w_gnt_i) begin
            w_resp_d = StRdI;
        end else if (w_gnt_d && !bus.dmem_we_i) begin
            w_resp_d = StRdD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_q <= StIdle;
        end else begin
            r_resp_q <= w_resp_d;
        end
    end

    always_comb begin
        w_rvalid_i        = (r_resp_q == StRdI);
        w_rvalid_d        = (r_resp_q == StRdD);
        bus.imem_rvalid_o = w_rvalid_i;
        bus.dmem_rvalid_o = w_rvalid_d;
        bus.imem_rdata_o  = w_rvalid_i ? bus.mem_rdata_i : '0;
        bus.dmem_rdata_o  = w_rvalid_d ? bus.mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: SRAM model, reference memory and response scoreboard.
// Honours RV_MEM_ARB_RR_EN to select the expected contention order.
module tb_rv_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic clk;
    logic rst_n;

    rv_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rv_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [31:0] sram    [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] q_i [$];
    logic [31:0] q_d [$];
    logic        pend_i = 1'b0;
    logic        pend_d = 1'b0;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Single-port SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                sram[bus.mem_addr_o[11:2]] <= merge(sram[bus.mem_addr_o[11:2]],
                                                    bus.mem_wdata_o, bus.mem_be_o);
            end else begin
                bus.mem_rdata_i <= sram[bus.mem_addr_o[11:2]];
            end
        end
    end

    // An ungranted request must stay asserted and stable until granted.
    logic        hold_i = 1'b0;
    logic        hold_d = 1'b0;
    logic [71:0] held_i;
    logic [71:0] held_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_i = 1'b0;
            hold_d = 1'b0;
        end else begin
            if (hold_i) check_eq("imem_hold", {39'd0, bus.imem_req_i, bus.imem_addr_i}, held_i);
            if (hold_d) check_eq("dmem_hold", {2'd0, bus.dmem_req_i, bus.dmem_we_i,
                                 bus.dmem_be_i, bus.dmem_addr_i, bus.dmem_wdata_i}, held_d);
            hold_i = bus.imem_req_i && !bus.imem_gnt_o;
            hold_d = bus.dmem_req_i && !bus.dmem_gnt_o;
            held_i = {39'd0, bus.imem_req_i, bus.imem_addr_i};
            held_d = {2'd0, bus.dmem_req_i, bus.dmem_we_i, bus.dmem_be_i,
                      bus.dmem_addr_i, bus.dmem_wdata_i};
        end
    end

    task automatic set_i(input logic [31:0] addr);
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = addr;
        q_i.push_back(ref_mem[addr[11:2]]);
    endtask

    task automatic set_d_rd(input logic [31:0] addr);
        bus.dmem_req_i   = 1'b1;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_be_i    = 4'h0;
        bus.dmem_addr_i  = addr;
        bus.dmem_wdata_i = $urandom;
        q_d.push_back(ref_mem[addr[11:2]]);
    endtask

    task automatic set_d_wr(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
        bus.dmem_req_i   = 1'b1;
        bus.dmem_we_i    = 1'b1;
        bus.dmem_be_i    = be;
        bus.dmem_addr_i  = addr;
        bus.dmem_wdata_i = data;
        ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], data, be);
    endtask

    // Called just after a rising edge; checks the cycle, then advances to just after the next edge.
    task automatic step(input logic eg_i, input logic eg_d);
        logic [31:0] exp_w;
        @(negedge clk);
        check_eq("imem_rvalid", {71'd0, bus.imem_rvalid_o}, {71'd0, pend_i});
        exp_w = 32'h0;
        if (pend_i) exp_w = (q_i.size() > 0) ? q_i.pop_front() : 32'hxxxx_xxxx;
        check_eq("imem_rdata", {40'd0, bus.imem_rdata_o}, {40'd0, exp_w});
        check_eq("dmem_rvalid", {71'd0, bus.dmem_rvalid_o}, {71'd0, pend_d});
        exp_w = 32'h0;
        if (pend_d) exp_w = (q_d.size() > 0) ? q_d.pop_front() : 32'hxxxx_xxxx;
        check_eq("dmem_rdata", {40'd0, bus.dmem_rdata_o}, {40'd0, exp_w});
        check_eq("imem_gnt", {71'd0, bus.imem_gnt_o}, {71'd0, eg_i});
        check_eq("dmem_gnt", {71'd0, bus.dmem_gnt_o}, {71'd0, eg_d});
        check_eq("mem_en", {71'd0, bus.mem_en_o}, {71'd0, eg_i | eg_d});
        if (eg_d) begin
            check_eq("mem_addr_d", {40'd0, bus.mem_addr_o}, {40'd0, bus.dmem_addr_i});
            check_eq("mem_we_d", {71'd0, bus.mem_we_o}, {71'd0, bus.dmem_we_i});
        end else if (eg_i) begin
            check_eq("mem_addr_i", {40'd0, bus.mem_addr_o}, {40'd0, bus.imem_addr_i});
            check_eq("mem_we_i", {67'd0, bus.mem_we_o, bus.mem_be_o}, 72'h0F);
        end
        pend_i = eg_i;
        pend_d = eg_d & ~bus.dmem_we_i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.imem_req_i = 1'b0;
        bus.dmem_req_i = 1'b0;
        bus.dmem_we_i  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            sram[k]    = 32'hA5A5_0000 ^ (k * 32'h0001_0103);
        end
        sram[32'h10 >> 2]  = 32'hDEAD_BEEF;
        sram[32'h100 >> 2] = 32'hAAAA_BBBB;
        for (int k = 0; k < 1024; k++) ref_mem[k] = sram[k];

        bus.imem_addr_i  = 32'h10;
        bus.dmem_addr_i  = 32'h200;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_be_i    = 4'h0;
        bus.dmem_wdata_i = 32'h0;
        bus.imem_req_i   = 1'b1;
        bus.dmem_req_i   = 1'b1;
        rst_n            = 1'b0;

        // Reset: both requesting, everything quiet.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_imem_gnt", {71'd0, bus.imem_gnt_o}, 72'd0);
        check_eq("rst_dmem_gnt", {71'd0, bus.dmem_gnt_o}, 72'd0);
        check_eq("rst_rvalid", {70'd0, bus.imem_rvalid_o, bus.dmem_rvalid_o}, 72'd0);
        check_eq("rst_mem_en", {71'd0, bus.mem_en_o}, 72'd0);
        check_eq("rst_mem_addr", {40'd0, bus.mem_addr_o}, 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dmem_req_i = 1'b0;
        set_i(32'h10);
        check_eq("first_word", {40'd0, q_i[0]}, {40'd0, 32'hDEAD_BEEF});
        step(1'b1, 1'b0);

        // Back-to-back fetch.
        set_i(32'h0); step(1'b1, 1'b0);
        set_i(32'h4); step(1'b1, 1'b0);
        set_i(32'h8); step(1'b1, 1'b0);
        idle_all();   step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Partial write then read-back.
        set_d_wr(32'h100, 32'h1234_5678, 4'b0011);
        check_eq("merge_ref", {40'd0, ref_mem[32'h100 >> 2]}, {40'd0, 32'hAAAA_5678});
        step(1'b0, 1'b1);
        set_d_rd(32'h100); step(1'b0, 1'b1);
        idle_all();        step(1'b0, 1'b0);

`ifndef RV_MEM_ARB_RR_EN
        // Fixed priority: data wins every contended cycle.
        set_i(32'h20);
        set_d_rd(32'h100); step(1'b0, 1'b1);
        set_d_rd(32'h104); step(1'b0, 1'b1);
        set_d_rd(32'h108); step(1'b0, 1'b1);
        bus.dmem_req_i = 1'b0;
        step(1'b1, 1'b0);
        idle_all();        step(1'b0, 1'b0);
`else
        // Round-robin: grants alternate, starting with fetch after reset.
        set_i(32'h0);
        set_d_rd(32'h100); step(1'b1, 1'b0);
        set_i(32'h4);      step(1'b0, 1'b1);
        set_d_rd(32'h104); step(1'b1, 1'b0);
        set_i(32'h8);      step(1'b0, 1'b1);
        bus.dmem_req_i = 1'b0;
        step(1'b1, 1'b0);
        idle_all();        step(1'b0, 1'b0);
`endif
        step(1'b0, 1'b0);

        // Reset pulse while a data read is outstanding.
        set_d_rd(32'h104);
        @(negedge clk);
        check_eq("midrd_gnt", {71'd0, bus.dmem_gnt_o}, 72'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrd_rst_gnt", {70'd0, bus.imem_gnt_o, bus.dmem_gnt_o}, 72'd0);
        check_eq("midrd_rst_en", {71'd0, bus.mem_en_o}, 72'd0);
        idle_all();
        #1 rst_n = 1'b1;
        pend_i = 1'b0;
        pend_d = 1'b0;
        q_d.delete();
        @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("scoreboard_empty", {40'd0, 32'(q_i.size() + q_d.size())}, 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard stop in case something above stops advancing.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
